// File: rtl/sort_arbiter.sv
// rtl/sort_arbiter.sv - round-robin arbiter sharing one fixed-latency wide sorter among R requesters
// Tags ride alongside the sorter pipeline so each sorted vector returns to its originating requester.
module sort_arbiter #(
  parameter int N   = 4,
  parameter int M   = 5,
  parameter int R   = 4,
  parameter int LAT = 2
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [R-1:0]               ReqValid,
  input  logic [N-1:0]               ReqData [R][M],
  output logic [R-1:0]               ReqReady,
  input  logic                       Drain,
  output logic [N-1:0]               SortX [M],
  input  logic [N-1:0]               SortY [M],
  output logic [R-1:0]               RspValid,
  output logic [N-1:0]               RspData [M],
  output logic [$clog2(LAT+1)-1:0]   InFlight,
  output logic                       Idle
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;
  localparam int IW = $clog2(LAT + 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_IDLE  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] grant_id;
  logic          accept;
  logic [PW:0]   scan_sum;
  logic [PW:0]   ptr_sum;
  logic [LAT-1:0] tag_v;
  logic [PW-1:0] tag_id [LAT];
  logic          rsp_fire;
  logic [IW-1:0] in_flight_next;

  // Rotating scan from ptr; reset is folded in so no grant is offered while held in reset.
  always_comb begin
    accept   = 1'b0;
    grant_id = '0;
    scan_sum = '0;
    ReqReady = '0;
    if (Reset && state == ST_RUN && !Drain) begin
      for (int k = 0; k < R; k++) begin
        scan_sum = {1'b0, ptr} + (PW+1)'(k);
        if (scan_sum >= (PW+1)'(R)) begin
          scan_sum = scan_sum - (PW+1)'(R);
        end
        if (!accept && ReqValid[scan_sum[PW-1:0]]) begin
          accept   = 1'b1;
          grant_id = scan_sum[PW-1:0];
        end
      end
    end
    if (accept) begin
      ReqReady[grant_id] = 1'b1;
    end
  end

  always_comb begin
    ptr_sum  = {1'b0, grant_id} + (PW+1)'(1);
    ptr_next = ptr_sum[PW-1:0];
    if (ptr_sum >= (PW+1)'(R)) begin
      ptr_next = '0;
    end
  end

  assign rsp_fire       = tag_v[LAT-1];
  assign in_flight_next = InFlight + IW'(accept) - IW'(rsp_fire);

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (Drain) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!Drain) begin
          state_next = ST_RUN;
        end else if (in_flight_next == '0) begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!Drain) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_RUN;
      ptr      <= '0;
      InFlight <= '0;
      tag_v    <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_id[s] <= '0;
      end
      for (int m = 0; m < M; m++) begin
        SortX[m] <= '0;
      end
    end else begin
      state    <= state_next;
      InFlight <= in_flight_next;
      if (accept) begin
        ptr <= ptr_next;
      end
      for (int m = 0; m < M; m++) begin
        SortX[m] <= accept ? ReqData[grant_id][m] : '0;
      end
      // Tag pipeline mirrors the sorter and never stalls.
      tag_v[0]  <= accept;
      tag_id[0] <= grant_id;
      for (int s = LAT - 1; s > 0; s--) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  always_comb begin
    RspValid = '0;
    if (rsp_fire) begin
      RspValid[tag_id[LAT-1]] = 1'b1;
    end
  end

  assign RspData = SortY;
  assign Idle    = (state == ST_IDLE);

endmodule

// File: tb/tb_sort_arbiter.sv
// tb/tb_sort_arbiter.sv - directed bench for sort_arbiter with a sorter model and response scoreboard
module tb_sort_arbiter;

  localparam int N   = 4;
  localparam int M   = 5;
  localparam int R   = 4;
  localparam int LAT = 2;
  localparam int W   = M * N;
  localparam int IW  = $clog2(LAT + 1);

  logic           Clk;
  logic           Reset;
  logic [R-1:0]   ReqValid;
  logic [N-1:0]   ReqData [R][M];
  logic [R-1:0]   ReqReady;
  logic           Drain;
  logic [N-1:0]   SortX [M];
  logic [N-1:0]   SortY [M];
  logic [R-1:0]   RspValid;
  logic [N-1:0]   RspData [M];
  logic [IW-1:0]  InFlight;
  logic           Idle;

  typedef struct {
    int          id;
    logic [W-1:0] data;
    int          due;
  } sb_item_t;

  sb_item_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [W-1:0] sort_y_p;

  sort_arbiter #(.N(N), .M(M), .R(R), .LAT(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqData(ReqData),
    .ReqReady(ReqReady), .Drain(Drain), .SortX(SortX), .SortY(SortY),
    .RspValid(RspValid), .RspData(RspData), .InFlight(InFlight), .Idle(Idle)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc++;

  function automatic logic [W-1:0] pack(input logic [N-1:0] a [M]);
    logic [W-1:0] p;
    for (int i = 0; i < M; i++) p[i*N +: N] = a[i];
    return p;
  endfunction

  function automatic logic [W-1:0] vec5(input int a0, a1, a2, a3, a4);
    return {N'(a4), N'(a3), N'(a2), N'(a1), N'(a0)};
  endfunction

  function automatic logic [W-1:0] sorted_pack(input logic [W-1:0] p);
    logic [N-1:0] e [M];
    logic [N-1:0] t;
    logic [W-1:0] q;
    for (int i = 0; i < M; i++) e[i] = p[i*N +: N];
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M - 1 - i; j++)
        if (e[j] > e[j+1]) begin
          t = e[j]; e[j] = e[j+1]; e[j+1] = t;
        end
    for (int i = 0; i < M; i++) q[i*N +: N] = e[i];
    return q;
  endfunction

  // Sorter model: ascending order, one register behind SortX (LAT-1 stages).
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) sort_y_p <= '0;
    else        sort_y_p <= sorted_pack(pack(SortX));
  end
  always_comb begin
    for (int i = 0; i < M; i++) SortY[i] = sort_y_p[i*N +: N];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [W-1:0] p);
    for (int i = 0; i < M; i++) ReqData[r][i] = p[i*N +: N];
  endtask

  task automatic push(input int id, input logic [W-1:0] d);
    sb_item_t it;
    it.id = id;
    it.data = d;
    it.due = cyc + LAT;
    sb.push_back(it);
  endtask

  task automatic push_req(input int id);
    push(id, sorted_pack(pack(ReqData[id])));
  endtask

  // Response checker: every cycle, RspValid must match the scoreboard head exactly when it is due.
  always @(negedge Clk) begin
    logic [R-1:0] exp_v;
    logic [W-1:0] exp_d;
    if (Reset) begin
      exp_v = '0;
      exp_d = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_v = R'(1) << sb[0].id;
        exp_d = sb[0].data;
        void'(sb.pop_front());
      end
      chk("rsp_valid", 64'(RspValid), 64'(exp_v));
      if (exp_v != '0) chk("rsp_data", 64'(pack(RspData)), 64'(exp_d));
    end
  end

  initial begin
    Reset = 1'b0;
    Drain = 1'b0;
    ReqValid = '0;
    for (int r = 0; r < R; r++) set_req(r, '0);
    repeat (2) @(negedge Clk);
    ReqValid = 4'b1111;
    #1;
    chk("rst_ready", 64'(ReqReady), 64'h0);
    chk("rst_rspvalid", 64'(RspValid), 64'h0);
    chk("rst_idle", 64'(Idle), 64'h0);
    chk("rst_inflight", 64'(InFlight), 64'h0);
    chk("rst_sortx", 64'(pack(SortX)), 64'h0);
    ReqValid = '0;
    @(negedge Clk);
    #2 Reset = 1'b1;

    // 1: single request from requester 2
    @(negedge Clk);
    set_req(2, vec5(15, 1, 7, 3, 0));
    ReqValid = 4'b0100;
    #1 chk("t1_grant", 64'(ReqReady), 64'h4);
    push(2, vec5(0, 1, 3, 7, 15));
    @(negedge Clk);
    ReqValid = '0;
    chk("t1_sortx", 64'(pack(SortX)), 64'(vec5(15, 1, 7, 3, 0)));
    chk("t1_inflight_a", 64'(InFlight), 64'h1);
    @(negedge Clk);
    chk("t1_sortx_zero", 64'(pack(SortX)), 64'h0);
    chk("t1_inflight_b", 64'(InFlight), 64'h1);
    @(negedge Clk);
    chk("t1_inflight_c", 64'(InFlight), 64'h0);

    // 2: all four valid right after reset
    #2 Reset = 1'b0;
    @(negedge Clk);
    #2 Reset = 1'b1;
    for (int r = 0; r < R; r++) set_req(r, W'($urandom));
    ReqValid = 4'b1111;
    for (int k = 0; k < R; k++) begin
      #1 chk("t2_grant", 64'(ReqReady), 64'(R'(1) << k));
      push_req(k);
      @(negedge Clk);
      ReqValid[k] = 1'b0;
    end
    repeat (3) @(negedge Clk);

    // 3: requesters 0 and 3 held valid, grants alternate and ptr wraps
    ReqValid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      set_req(0, W'($urandom));
      set_req(3, W'($urandom));
      #1 chk("t3_grant", 64'(ReqReady), (i % 2 == 0) ? 64'h1 : 64'h8);
      push_req((i % 2 == 0) ? 0 : 3);
      @(negedge Clk);
    end
    ReqValid = '0;
    repeat (3) @(negedge Clk);

    // 4: drain with two in flight
    set_req(1, W'($urandom));
    set_req(2, W'($urandom));
    ReqValid = 4'b0110;
    #1 chk("t4_grant1", 64'(ReqReady), 64'h2);
    push_req(1);
    @(negedge Clk);
    ReqValid = 4'b0100;
    #1 chk("t4_grant2", 64'(ReqReady), 64'h4);
    push_req(2);
    @(negedge Clk);
    Drain = 1'b1;
    ReqValid = 4'b1111;
    #1 chk("t4_block_a", 64'(ReqReady), 64'h0);
    chk("t4_inflight_2", 64'(InFlight), 64'h2);
    @(negedge Clk);
    chk("t4_block_b", 64'(ReqReady), 64'h0);
    chk("t4_idle_lo", 64'(Idle), 64'h0);
    chk("t4_inflight_1", 64'(InFlight), 64'h1);
    @(negedge Clk);
    chk("t4_idle_hi", 64'(Idle), 64'h1);
    chk("t4_inflight_0", 64'(InFlight), 64'h0);
    chk("t4_block_c", 64'(ReqReady), 64'h0);
    @(negedge Clk);
    chk("t4_idle_hold", 64'(Idle), 64'h1);
    Drain = 1'b0;
    #1 chk("t4_idle_nogrant", 64'(ReqReady), 64'h0);
    @(negedge Clk);
    chk("t4_run", 64'(Idle), 64'h0);
    set_req(3, W'($urandom));
    #1 chk("t4_resume", 64'(ReqReady), 64'h8);
    push_req(3);
    @(negedge Clk);
    ReqValid = '0;
    repeat (3) @(negedge Clk);

    // 5: reset mid-flight with two tags valid
    set_req(0, W'($urandom));
    set_req(1, W'($urandom));
    ReqValid = 4'b0011;
    #1 chk("t5_grant0", 64'(ReqReady), 64'h1);
    push_req(0);
    @(negedge Clk);
    ReqValid = 4'b0010;
    #1 chk("t5_grant1", 64'(ReqReady), 64'h2);
    push_req(1);
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk("t5_rspvalid", 64'(RspValid), 64'h0);
    chk("t5_sortx", 64'(pack(SortX)), 64'h0);
    chk("t5_inflight", 64'(InFlight), 64'h0);
    chk("t5_ready", 64'(ReqReady), 64'h0);
    chk("t5_idle", 64'(Idle), 64'h0);
    @(negedge Clk);
    sb.delete();
    ReqValid = 4'b1010;
    set_req(1, W'($urandom));
    #2 Reset = 1'b1;
    #1 chk("t5_post_grant", 64'(ReqReady), 64'h2);
    push_req(1);
    @(negedge Clk);
    ReqValid = '0;
    repeat (3) @(negedge Clk);

    // 6: quiet inputs for 10 cycles, ptr must survive
    for (int i = 0; i < 10; i++) begin
      chk("t6_sortx", 64'(pack(SortX)), 64'h0);
      chk("t6_inflight", 64'(InFlight), 64'h0);
      @(negedge Clk);
    end
    for (int r = 0; r < R; r++) set_req(r, W'($urandom));
    ReqValid = 4'b1111;
    #1 chk("t6_ptr_kept", 64'(ReqReady), 64'h4);
    push_req(2);
    @(negedge Clk);
    ReqValid = '0;
    repeat (3) @(negedge Clk);
    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
